// File: rtl/cache_refill_ctrl_pkg.sv
// Shared types and helpers for the data-cache refill controller.
//   refill_state_t : controller states (IDLE, REFILL, WRITE)
//   OFFSET_W/BEAT_W: line-offset and beat-counter widths for the default line size
//   line_base()    : clears the low offset bits of a byte address
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } refill_state_t;

  localparam int unsigned BLOCK_WORDS_DEF = 4;
  localparam int unsigned BEAT_W          = $clog2(BLOCK_WORDS_DEF);
  localparam int unsigned OFFSET_W        = BEAT_W + 2;
  localparam int unsigned ADDR_MAX_W      = 64;

  // Line base of a byte address; callers widen to ADDR_MAX_W and truncate back.
  function automatic logic [ADDR_MAX_W-1:0] line_base(input logic [ADDR_MAX_W-1:0] addr,
                                                      input int unsigned            offset_w);
    logic [ADDR_MAX_W-1:0] mask;
    mask = {ADDR_MAX_W{1'b1}} << offset_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Main-memory port of the refill controller.
//   master : controller side (drives request/address/data, receives ready/rdata)
//   slave  : memory side
interface cache_refill_ctrl_if #(
  parameter int unsigned WD = 32,
  parameter int unsigned AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [WD-1:0] mem_wdata;
  logic          mem_ready;
  logic [WD-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss-side controller of the data cache: refills whole lines on load misses,
// writes them into the data/tag arrays, and performs write-through stores.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_we/req_addr/
//   req_wdata/hit                    : CPU access and tag-compare result
//   stall                            : pipeline freeze (combinational)
//   mem                              : main-memory port (registered request side)
//   cache_we/cache_waddr/cache_wdata : one-word write into the cache data array
//   tag_we                           : write tag and set valid for the filled line
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WD          = 32,
  parameter int unsigned AW          = 32,
  parameter int unsigned BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [AW-1:0]       req_addr,
  input  logic [WD-1:0]       req_wdata,
  input  logic                hit,
  output logic                stall,
  cache_refill_ctrl_if.master mem,
  output logic                cache_we,
  output logic [AW-1:0]       cache_waddr,
  output logic [WD-1:0]       cache_wdata,
  output logic                tag_we
);

  localparam int unsigned BEAT_BITS = $clog2(BLOCK_WORDS);
  localparam int unsigned OFF_BITS  = BEAT_BITS + 2;
  localparam int unsigned LAST_BEAT = BLOCK_WORDS - 1;

  refill_state_t         state_q;
  logic [BEAT_BITS-1:0]  beat_q;
  logic [AW-1:0]         base_q;
  logic                  hit_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [AW-1:0]         mem_addr_q;
  logic [WD-1:0]         mem_wdata_q;

  logic                  load_miss;
  logic                  store;
  logic                  beat_last;
  logic [BEAT_BITS-1:0]  beat_nxt;
  logic [AW-1:0]         req_base;
  logic [AW-1:0]         nxt_beat_addr;

  assign load_miss     = req_valid & ~req_we & ~hit;
  assign store         = req_valid & req_we;
  assign beat_last     = (beat_q == BEAT_BITS'(LAST_BEAT));
  // Counter wraps to zero after the last beat, so the address never leaves the line.
  assign beat_nxt      = beat_q + BEAT_BITS'(1);
  assign req_base      = AW'(line_base(ADDR_MAX_W'(req_addr), OFF_BITS));
  assign nxt_beat_addr = base_q | (AW'(beat_nxt) << 2);

  // State, beat counter, latches and the registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      base_q      <= '0;
      hit_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (store) begin
            state_q     <= WRITE;
            hit_q       <= hit;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= req_addr;
            mem_wdata_q <= req_wdata;
          end else if (load_miss) begin
            state_q    <= REFILL;
            base_q     <= req_base;
            beat_q     <= '0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= req_base;
          end
        end
        REFILL: begin
          if (mem.mem_ready) begin
            beat_q <= beat_nxt;
            if (beat_last) begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end else begin
              mem_addr_q <= nxt_beat_addr;
            end
          end
        end
        WRITE: begin
          if (mem.mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  // Stall and cache write strobes react to this cycle's request/ready.
  always_comb begin
    stall       = 1'b0;
    cache_we    = 1'b0;
    cache_wdata = '0;
    tag_we      = 1'b0;
    case (state_q)
      IDLE: begin
        stall = req_valid & (req_we | ~hit);
      end
      REFILL: begin
        stall       = 1'b1;
        cache_we    = mem.mem_ready;
        cache_wdata = mem.mem_rdata;
        tag_we      = mem.mem_ready & beat_last;
      end
      WRITE: begin
        stall       = ~mem.mem_ready;
        // No-write-allocate: only a store that hit updates the cached copy.
        cache_we    = mem.mem_ready & hit_q;
        cache_wdata = mem_wdata_q;
      end
      default: ;
    endcase
  end

  assign cache_waddr = mem_addr_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl against a transaction-level model of
// the line refill and write-through store behaviour.
module tb_cache_refill_ctrl;

  localparam int unsigned WD = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [WD-1:0] req_wdata;
  logic          hit;
  logic          stall;
  logic          cache_we;
  logic [AW-1:0] cache_waddr;
  logic [WD-1:0] cache_wdata;
  logic          tag_we;

  int n_vec = 0;
  int n_mis = 0;

  cache_refill_ctrl_if #(.WD(WD), .AW(AW)) bus ();

  cache_refill_ctrl #(.WD(WD), .AW(AW), .BLOCK_WORDS(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .hit         (hit),
    .stall       (stall),
    .mem         (bus),
    .cache_we    (cache_we),
    .cache_waddr (cache_waddr),
    .cache_wdata (cache_wdata),
    .tag_we      (tag_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Load: hit needs no memory; a miss fetches BW beats from the line base.
  // fix_beat>=0 forces fix_wait wait cycles before that beat (others none);
  // rst_beat>=0 pulses reset on the first cycle of that beat and abandons the line.
  task automatic do_load(input logic [AW-1:0] a, input logic h, input int wmax,
                         input int fix_beat, input int fix_wait, input int rst_beat,
                         input logic seq_data);
    logic [AW-1:0] base;
    logic [AW-1:0] exp_addr;
    logic [WD-1:0] rd;
    logic          rdy;
    int            stalls;
    int            waits_total;
    int            w;
    base        = a & ~AW'(BW * 4 - 1);
    stalls      = 0;
    waits_total = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = $urandom; hit = h;
    bus.mem_ready = 1'($urandom); bus.mem_rdata = $urandom;
    @(negedge clk);
    chk("ld_idle_stall", stall, !h);
    chk("ld_idle_memreq", bus.mem_req, 1'b0);
    chk("ld_idle_cwe", cache_we, 1'b0);
    if (stall) stalls++;
    if (!h) begin
      for (int k = 0; k < BW; k++) begin
        if (fix_beat >= 0) w = (k == fix_beat) ? fix_wait : 0;
        else               w = $urandom_range(wmax, 0);
        waits_total += w;
        exp_addr = base + AW'(4 * k);
        for (int c = 0; c <= w; c++) begin
          rdy = (c == w);
          @(posedge clk); #1;
          req_valid = 1'($urandom); req_we = 1'($urandom);
          req_addr = $urandom; req_wdata = $urandom; hit = 1'($urandom);
          rd = seq_data ? WD'(32'hA0 + k) : WD'($urandom);
          bus.mem_ready = rdy; bus.mem_rdata = rd;
          if (k == rst_beat) rst = 1'b1;
          @(negedge clk);
          chk("rf_memreq", bus.mem_req, 1'b1);
          chk("rf_memwe", bus.mem_we, 1'b0);
          chk("rf_addr", bus.mem_addr, exp_addr);
          chk("rf_stall", stall, 1'b1);
          chk("rf_cwe", cache_we, rdy);
          chk("rf_tagwe", tag_we, rdy && (k == BW - 1));
          if (rdy) begin
            chk("rf_cwaddr", cache_waddr, exp_addr);
            chk("rf_cwdata", cache_wdata, rd);
          end
          if (stall) stalls++;
          if (k == rst_beat) begin
            @(posedge clk); #1;
            rst = 1'b0; req_valid = 1'b0; bus.mem_ready = 1'b1;
            @(negedge clk);
            chk("rst_memreq", bus.mem_req, 1'b0);
            chk("rst_addr", bus.mem_addr, '0);
            chk("rst_stall", stall, 1'b0);
            chk("rst_tagwe", tag_we, 1'b0);
            chk("rst_cwe", cache_we, 1'b0);
            return;
          end
        end
      end
      @(posedge clk); #1;
      req_valid = 1'b0; bus.mem_ready = 1'($urandom);
      @(negedge clk);
      chk("ld_end_memreq", bus.mem_req, 1'b0);
      chk("ld_end_stall", stall, 1'b0);
      chk("ld_end_tagwe", tag_we, 1'b0);
      chk("ld_end_cwe", cache_we, 1'b0);
      chk("ld_stall_cnt", 64'(stalls), 64'(1 + BW + waits_total));
    end else begin
      chk("hit_stall_cnt", 64'(stalls), 64'd0);
    end
  endtask

  // Store: one detect cycle, then a held memory write until ready.
  task automatic do_store(input logic [AW-1:0] a, input logic [WD-1:0] d, input logic h,
                          input int wmax, input int fix_wait);
    logic rdy;
    int   stalls;
    int   w;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; hit = h;
    bus.mem_ready = 1'($urandom); bus.mem_rdata = $urandom;
    @(negedge clk);
    chk("st_idle_stall", stall, 1'b1);
    chk("st_idle_memreq", bus.mem_req, 1'b0);
    chk("st_idle_cwe", cache_we, 1'b0);
    stalls = 1;
    w = (fix_wait >= 0) ? fix_wait : int'($urandom_range(wmax, 0));
    for (int c = 0; c <= w; c++) begin
      rdy = (c == w);
      @(posedge clk); #1;
      req_valid = 1'($urandom); req_we = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom; hit = 1'($urandom);
      bus.mem_ready = rdy; bus.mem_rdata = $urandom;
      @(negedge clk);
      chk("wr_memreq", bus.mem_req, 1'b1);
      chk("wr_memwe", bus.mem_we, 1'b1);
      chk("wr_addr", bus.mem_addr, a);
      chk("wr_wdata", bus.mem_wdata, d);
      chk("wr_stall", stall, !rdy);
      chk("wr_cwe", cache_we, rdy && h);
      chk("wr_tagwe", tag_we, 1'b0);
      if (rdy && h) begin
        chk("wr_cwaddr", cache_waddr, a);
        chk("wr_cwdata", cache_wdata, d);
      end
      if (stall) stalls++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; bus.mem_ready = 1'($urandom);
    @(negedge clk);
    chk("st_end_memreq", bus.mem_req, 1'b0);
    chk("st_end_memwe", bus.mem_we, 1'b0);
    chk("st_end_stall", stall, 1'b0);
    chk("st_stall_cnt", 64'(stalls), 64'(1 + w));
  endtask

  initial begin
    logic [AW-1:0] ra;
    int            op;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; hit = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_v_stall", stall, 1'b0);
    chk("rst_v_memreq", bus.mem_req, 1'b0);
    chk("rst_v_memwe", bus.mem_we, 1'b0);
    chk("rst_v_addr", bus.mem_addr, '0);
    chk("rst_v_wdata", bus.mem_wdata, '0);
    chk("rst_v_cwe", cache_we, 1'b0);
    chk("rst_v_cwaddr", cache_waddr, '0);
    chk("rst_v_cwdata", cache_wdata, '0);
    chk("rst_v_tagwe", tag_we, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_load(32'h0000_0104, 1'b0, 0, -1, 0, -1, 1'b1);
    do_load(32'h0000_0104, 1'b0, 0, 1, 2, -1, 1'b1);
    do_store(32'h0000_0200, 32'hDEAD_BEEF, 1'b1, 0, 1);
    do_store(32'h0000_0300, 32'h1234_5678, 1'b0, 0, 0);
    do_load(32'h0000_0408, 1'b0, 0, -1, 0, 2, 1'b0);
    do_load(32'h0000_0500, 1'b0, 0, -1, 0, -1, 1'b0);
    for (int i = 0; i < 4; i++) do_load(AW'($urandom) & ~AW'(3), 1'b1, 0, -1, 0, -1, 1'b0);

    for (int i = 0; i < 120; i++) begin
      ra = AW'($urandom) & ~AW'(3);
      op = $urandom_range(4, 0);
      case (op)
        0:       do_load(ra, 1'b1, 3, -1, 0, -1, 1'b0);
        1, 2:    do_load(ra, 1'b0, 3, -1, 0, -1, 1'b0);
        3:       do_store(ra, $urandom, 1'b1, 3, -1);
        default: do_store(ra, $urandom, 1'b0, 3, -1);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
